ift_boot_rom_arbiter: RTL and testbench
=======================================

Name: ift_boot_rom_arbiter

Overview:
- Shares the single-port tainted boot ROM (1-cycle registered read, active-low csn, 32-bit word) between NumPorts requesters, e.g. core instruction fetch and debug/data bus.
- Round-robin grant, range/write checking and response routing.
- Carries CellIFT-style taint (_t0) alongside every data signal, so the tainted SoC keeps conservative information-flow tracking through the arbiter.

Parameters:
- NumPorts, 2, number of requesters (2..8).
- AddrOffset, 32'h1A000000, byte base address of the ROM window.
- ROM_ADDR_WIDTH, 13, ROM window size in bytes as log2; the window is [AddrOffset, AddrOffset + 2^ROM_ADDR_WIDTH).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock; reset is synchronous and active-low
- req_i  in  NumPorts  request per port
- add_i  in  NumPorts x 32  byte address per port
- wen_i  in  NumPorts  write-enable, active low (0 = write)
- gnt_o  out  NumPorts  grant, same cycle as req
- rvalid_o  out  NumPorts  response valid
- rdata_o  out  NumPorts x 32  response data
- err_o  out  NumPorts  response error, qualified by rvalid_o
- rom_csn_o  out  1  ROM chip select, active low
- rom_add_o  out  32  ROM address
- rom_wen_o  out  1  tied 1 (read)
- rom_rdata_i  in  32  ROM read data, valid one cycle after rom_csn_o=0
- req_i_t0, add_i_t0, wen_i_t0  in  same widths as base signals  input taints
- rom_rdata_i_t0  in  32  ROM data taint
- gnt_o_t0, rvalid_o_t0, rdata_o_t0, err_o_t0, rom_csn_o_t0, rom_add_o_t0  out  same widths as base signals  output taints

Behaviour:
- State: rr_q (last winner index); resp_vld_q, resp_idx_q, resp_err_q, resp_t_q (address/wen taint of granted request), resp_vld_t_q.
- Reset (rst_ni=0 at posedge):
  - rr_q = NumPorts-1, so port 0 wins first.
  - resp_vld_q = 0 and all response taint registers = 0.
  - Consequently rvalid_o = 0, err_o = 0, rdata_o = 0, all _t0 outputs = 0, rom_csn_o = 1.
- Arbitration (combinational):
  - Search starts at (rr_q+1) mod NumPorts, wraps around, and stops at the first port with req_i=1.
  - Exactly one gnt_o bit is set when any request is pending; none otherwise.
  - rr_q <= winner on each grant; rr_q is unchanged when idle.
- Every grant is accepted; there are no stalls. Throughput is 1 request/cycle, and back-to-back grants are allowed.
- Legal request: wen_i=1 and add_i is inside the ROM window.
  - rom_csn_o = 0.
  - rom_add_o = add_i - AddrOffset, passed whole; the ROM uses the word index itself.
- Illegal request (write, or address out of window):
  - Still granted, but rom_csn_o = 1.
  - resp_err_q = 1.
- Response: exactly 1 cycle after grant.
  - rvalid_o[resp_idx_q] = 1; all other rvalid_o bits are 0.
  - rdata_o[resp_idx_q] = rom_rdata_i on a legal request, 32'h0 on an error. rdata_o of non-responding ports = 0.
  - err_o[resp_idx_q] = resp_err_q.
- Window boundary: AddrOffset + 2^ROM_ADDR_WIDTH - 4 is legal; AddrOffset + 2^ROM_ADDR_WIDTH is an error. Addresses below AddrOffset are errors; do not wrap on subtraction.
- Taint rules (conservative):
  - gnt_o_t0[k] = OR over all j of req_i_t0[j], because any tainted contender can influence the grant.
  - rom_csn_o_t0 = gnt taint | winner add/wen taint (any bit).
  - rom_add_o_t0 = add_i_t0 of the winner.
  - resp_t_q = |add_i_t0[winner] | wen_i_t0[winner].
  - rvalid_o_t0[resp_idx_q] = resp_vld_t_q, the registered gnt_o_t0 of the winner.
  - rdata_o_t0[resp_idx_q] = legal ? rom_rdata_i_t0 | {32{resp_t_q}} : {32{resp_t_q}}.
  - err_o_t0[resp_idx_q] = resp_t_q.
  - Taint outputs of non-responding ports = 0.
- Reset mid-operation: an in-flight response is dropped (no rvalid), and the ROM output in the following cycle is ignored.
- rst_ni_t0 and clk_i_t0 are not modelled; reset taint is outside scope.

Test Plan:
- Reset, then port0 reads 32'h1A000010 with ROM word 4 = 32'hDEADBEEF → gnt_o=2'b01 the same cycle; next cycle rvalid_o=2'b01, rdata_o[0]=32'hDEADBEEF, err_o=0, rom_add_o=32'h10.
- Both ports request continuously for 4 cycles → grants alternate 01,10,01,10; each rvalid lands on the matching port one cycle later.
- Port1 write (wen_i=0) and port1 read at 32'h1A002000 (just past the 8 KiB window) → both granted, rom_csn_o=1, err_o[1]=1, rdata_o[1]=0.
- Port0 read with add_i_t0=32'h4 and ROM taint 0 → rdata_o_t0[0]=32'hFFFFFFFF, err_o_t0[0]=1; same read with add_i_t0=0 and rom_rdata_i_t0=32'h000000FF → rdata_o_t0[0]=32'h000000FF.
- req_i_t0[1]=1 while only port0 requests → gnt_o_t0=2'b11, rvalid_o_t0[0]=1 next cycle.
- Assert rst_ni=0 in the cycle after a grant → no rvalid_o the next cycle; first post-reset grant goes to port 0 when both request.

Source files
------------

// File: rtl/ift_boot_rom_arbiter.sv
// ift_boot_rom_arbiter
//
// Shares one single-port boot ROM (1-cycle registered read, active-low chip
// select, 32-bit words) between NumPorts requesters with round-robin
// arbitration. Requests that write or fall outside the ROM window are still
// granted, but they do not touch the ROM and they answer with an error. Every
// data signal carries a CellIFT-style taint companion (_t0), which is
// propagated conservatively.
//
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   req_i/add_i/wen_i        per-port request, byte address, write enable (0 = write)
//   gnt_o                    per-port grant, combinational in the request cycle
//   rvalid_o/rdata_o/err_o   per-port response, one cycle after the grant
//   rom_csn_o/add_o/wen_o    ROM request (address relative to AddrOffset)
//   rom_rdata_i              ROM read data, valid one cycle after rom_csn_o = 0
//   *_t0                     taint companions of the signals above

module ift_boot_rom_arbiter #(
    parameter int unsigned NumPorts       = 2,
    parameter logic [31:0] AddrOffset     = 32'h1A00_0000,
    parameter int unsigned ROM_ADDR_WIDTH = 13
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,

    input  logic [NumPorts-1:0]      req_i,
    input  logic [NumPorts*32-1:0]   add_i,
    input  logic [NumPorts-1:0]      wen_i,
    output logic [NumPorts-1:0]      gnt_o,
    output logic [NumPorts-1:0]      rvalid_o,
    output logic [NumPorts*32-1:0]   rdata_o,
    output logic [NumPorts-1:0]      err_o,

    output logic                     rom_csn_o,
    output logic [31:0]              rom_add_o,
    output logic                     rom_wen_o,
    input  logic [31:0]              rom_rdata_i,

    input  logic [NumPorts-1:0]      req_i_t0,
    input  logic [NumPorts*32-1:0]   add_i_t0,
    input  logic [NumPorts-1:0]      wen_i_t0,
    input  logic [31:0]              rom_rdata_i_t0,

    output logic [NumPorts-1:0]      gnt_o_t0,
    output logic [NumPorts-1:0]      rvalid_o_t0,
    output logic [NumPorts*32-1:0]   rdata_o_t0,
    output logic [NumPorts-1:0]      err_o_t0,
    output logic                     rom_csn_o_t0,
    output logic [31:0]              rom_add_o_t0
);

    localparam int unsigned IdxW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

    // ------------------------------------------------------------------
    // Per-port views of the flat buses
    // ------------------------------------------------------------------
    logic [31:0] add_arr     [NumPorts];
    logic [31:0] add_t_arr   [NumPorts];
    logic [31:0] rdata_arr   [NumPorts];
    logic [31:0] rdata_t_arr [NumPorts];

    for (genvar g = 0; g < NumPorts; g++) begin : g_ports
        assign add_arr[g]              = add_i[g*32 +: 32];
        assign add_t_arr[g]            = add_i_t0[g*32 +: 32];
        assign rdata_o[g*32 +: 32]     = rdata_arr[g];
        assign rdata_o_t0[g*32 +: 32]  = rdata_t_arr[g];
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [IdxW-1:0] rr_q, rr_d;
    logic            resp_vld_q, resp_vld_d;
    logic [IdxW-1:0] resp_idx_q, resp_idx_d;
    logic            resp_err_q, resp_err_d;
    logic            resp_t_q, resp_t_d;
    logic            resp_vld_t_q, resp_vld_t_d;

    // ------------------------------------------------------------------
    // Round-robin search, starting one past the last winner
    // ------------------------------------------------------------------
    logic            any_req;
    logic [IdxW-1:0] win_idx;
    int unsigned     cand;
    logic [IdxW-1:0] cand_idx;

    always_comb begin
        any_req  = 1'b0;
        win_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned i = 1; i <= NumPorts; i++) begin
            cand = 32'(rr_q) + i;
            if (cand >= NumPorts) begin
                cand = cand - NumPorts;
            end
            cand_idx = IdxW'(cand);
            if (!any_req && req_i[cand_idx]) begin
                any_req = 1'b1;
                win_idx = cand_idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Winner decode and window check
    // ------------------------------------------------------------------
    logic [31:0] win_add;
    logic [31:0] win_off;
    logic        win_in_window;
    logic        win_legal;
    logic        win_taint;
    logic        gnt_taint;

    always_comb begin
        win_add       = add_arr[win_idx];
        win_off       = win_add - AddrOffset;
        // The lower-bound compare keeps addresses below the window from
        // wrapping into it through the subtraction.
        win_in_window = (win_add >= AddrOffset) && ((win_off >> ROM_ADDR_WIDTH) == 32'd0);
        win_legal     = wen_i[win_idx] && win_in_window;
        win_taint     = (|add_t_arr[win_idx]) | wen_i_t0[win_idx];
        // Any tainted contender can change who wins, so all grants inherit it.
        gnt_taint     = |req_i_t0;
    end

    // ------------------------------------------------------------------
    // Request-side outputs
    // ------------------------------------------------------------------
    always_comb begin
        gnt_o        = '0;
        rom_csn_o    = 1'b1;
        rom_add_o    = '0;
        rom_wen_o    = 1'b1;
        gnt_o_t0     = {NumPorts{gnt_taint}};
        rom_csn_o_t0 = gnt_taint;
        rom_add_o_t0 = '0;
        if (any_req) begin
            gnt_o[win_idx] = 1'b1;
            rom_csn_o      = ~win_legal;
            rom_add_o      = win_off;
            rom_csn_o_t0   = gnt_taint | win_taint;
            rom_add_o_t0   = add_t_arr[win_idx];
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        rr_d         = rr_q;
        resp_vld_d   = any_req;
        resp_idx_d   = resp_idx_q;
        resp_err_d   = 1'b0;
        resp_t_d     = 1'b0;
        resp_vld_t_d = 1'b0;
        if (any_req) begin
            rr_d         = win_idx;
            resp_idx_d   = win_idx;
            resp_err_d   = ~win_legal;
            resp_t_d     = win_taint;
            resp_vld_t_d = gnt_taint;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_q         <= IdxW'(NumPorts - 1);
            resp_vld_q   <= 1'b0;
            resp_idx_q   <= '0;
            resp_err_q   <= 1'b0;
            resp_t_q     <= 1'b0;
            resp_vld_t_q <= 1'b0;
        end else begin
            rr_q         <= rr_d;
            resp_vld_q   <= resp_vld_d;
            resp_idx_q   <= resp_idx_d;
            resp_err_q   <= resp_err_d;
            resp_t_q     <= resp_t_d;
            resp_vld_t_q <= resp_vld_t_d;
        end
    end

    // ------------------------------------------------------------------
    // Response routing: only the port granted last cycle sees anything
    // ------------------------------------------------------------------
    always_comb begin
        rvalid_o    = '0;
        err_o       = '0;
        rvalid_o_t0 = '0;
        err_o_t0    = '0;
        for (int unsigned p = 0; p < NumPorts; p++) begin
            rdata_arr[p]   = '0;
            rdata_t_arr[p] = '0;
        end
        if (resp_vld_q) begin
            rvalid_o[resp_idx_q]    = 1'b1;
            err_o[resp_idx_q]       = resp_err_q;
            rvalid_o_t0[resp_idx_q] = resp_vld_t_q;
            err_o_t0[resp_idx_q]    = resp_t_q;
            if (resp_err_q) begin
                // The ROM was not selected, so its data is neither returned
                // nor allowed to contribute taint.
                rdata_t_arr[resp_idx_q] = {32{resp_t_q}};
            end else begin
                rdata_arr[resp_idx_q]   = rom_rdata_i;
                rdata_t_arr[resp_idx_q] = rom_rdata_i_t0 | {32{resp_t_q}};
            end
        end
    end

endmodule

// File: tb/tb_ift_boot_rom_arbiter.sv
module tb_ift_boot_rom_arbiter;

    localparam int          NP   = 2;
    localparam logic [31:0] OFF  = 32'h1A00_0000;
    localparam int          ROMW = 13;

    logic          clk;
    logic          rst_n;
    logic [1:0]    req, wen, req_t, wen_t;
    logic [63:0]   add, add_t;
    logic [31:0]   rom_rdata, rom_t;

    logic [1:0]    gnt_o, rvalid_o, err_o, gnt_o_t0, rvalid_o_t0, err_o_t0;
    logic [63:0]   rdata_o, rdata_o_t0;
    logic          rom_csn_o, rom_wen_o, rom_csn_o_t0;
    logic [31:0]   rom_add_o, rom_add_o_t0;

    ift_boot_rom_arbiter #(
        .NumPorts       (NP),
        .AddrOffset     (OFF),
        .ROM_ADDR_WIDTH (ROMW)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_i          (req),
        .add_i          (add),
        .wen_i          (wen),
        .gnt_o          (gnt_o),
        .rvalid_o       (rvalid_o),
        .rdata_o        (rdata_o),
        .err_o          (err_o),
        .rom_csn_o      (rom_csn_o),
        .rom_add_o      (rom_add_o),
        .rom_wen_o      (rom_wen_o),
        .rom_rdata_i    (rom_rdata),
        .req_i_t0       (req_t),
        .add_i_t0       (add_t),
        .wen_i_t0       (wen_t),
        .rom_rdata_i_t0 (rom_t),
        .gnt_o_t0       (gnt_o_t0),
        .rvalid_o_t0    (rvalid_o_t0),
        .rdata_o_t0     (rdata_o_t0),
        .err_o_t0       (err_o_t0),
        .rom_csn_o_t0   (rom_csn_o_t0),
        .rom_add_o_t0   (rom_add_o_t0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // ROM contents: word 4 holds DEADBEEF, the rest a simple address pattern.
    function automatic logic [31:0] rom_word(input logic [29:0] idx);
        if (idx == 30'd4) return 32'hDEAD_BEEF;
        return {~idx[15:0], idx[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // Reference model state: last winner and the pending response.
    int          m_last;
    bit          p_vld;
    int          p_port;
    bit          p_legal, p_t, p_gt;
    logic [29:0] p_word;
    // Decisions for the current cycle.
    int          c_win;
    bit          c_legal, c_wt, c_gt;
    logic [29:0] c_word;
    // ROM-side registered request.
    bit          rom_prev_csn;
    logic [31:0] rom_prev_add;

    task automatic set_idle();
        req   = 2'b00;
        wen   = 2'b11;
        add   = '0;
        req_t = '0;
        add_t = '0;
        wen_t = '0;
        rom_t = '0;
    endtask

    task automatic begin_cycle();
        longint      off;
        logic [31:0] a;
        logic [63:0] e_rd, e_rdt;
        logic [1:0]  e_rv, e_err, e_rvt, e_errt, e_gnt;
        // The ROM answers the access it latched at the previous edge.
        rom_rdata = rom_prev_csn ? (32'hBAD0_0000 | 32'($urandom_range(0, 65535)))
                                 : rom_word(rom_prev_add[31:2]);
        #2;
        c_gt    = |req_t;
        c_win   = -1;
        c_legal = 0;
        c_wt    = 0;
        c_word  = '0;
        for (int k = 1; k <= NP; k++) begin
            int p;
            p = (m_last + k) % NP;
            if (c_win < 0 && req[p]) c_win = p;
        end
        if (c_win >= 0) begin
            a       = add[c_win*32 +: 32];
            off     = longint'({32'h0, a}) - longint'({32'h0, OFF});
            c_legal = wen[c_win] && off >= 0 && off < (longint'(1) << ROMW);
            c_word  = 30'(off >> 2);
            c_wt    = (add_t[c_win*32 +: 32] != 0) || wen_t[c_win];
        end
        if (rst_n) begin
            e_gnt = '0;
            if (c_win >= 0) e_gnt[c_win] = 1'b1;
            chk("gnt", gnt_o, e_gnt);
            chk("rom_csn", rom_csn_o, !(c_win >= 0 && c_legal));
            if (c_win >= 0 && c_legal) chk("rom_add", rom_add_o, 32'(off));
            chk("rom_wen", rom_wen_o, 1'b1);
            chk("gnt_t", gnt_o_t0, {2{c_gt}});
            chk("rom_csn_t", rom_csn_o_t0, c_gt || (c_win >= 0 && c_wt));
            chk("rom_add_t", rom_add_o_t0, (c_win >= 0) ? add_t[c_win*32 +: 32] : 32'h0);
        end
        e_rv = '0; e_err = '0; e_rvt = '0; e_errt = '0; e_rd = '0; e_rdt = '0;
        if (p_vld) begin
            e_rv[p_port]   = 1'b1;
            e_err[p_port]  = !p_legal;
            e_rvt[p_port]  = p_gt;
            e_errt[p_port] = p_t;
            e_rd[p_port*32 +: 32]  = p_legal ? rom_word(p_word) : 32'h0;
            e_rdt[p_port*32 +: 32] = p_legal ? (rom_t | {32{p_t}}) : {32{p_t}};
        end
        chk("rvalid", rvalid_o, e_rv);
        chk("err", err_o, e_err);
        chk("rdata", rdata_o, e_rd);
        chk("rvalid_t", rvalid_o_t0, e_rvt);
        chk("err_t", err_o_t0, e_errt);
        chk("rdata_t", rdata_o_t0, e_rdt);
    endtask

    task automatic end_cycle();
        bit was_rst;
        was_rst      = !rst_n;
        rom_prev_csn = rom_csn_o;
        rom_prev_add = rom_add_o;
        @(posedge clk);
        #1;
        if (was_rst) begin
            m_last = NP - 1;
            p_vld  = 0;
        end else begin
            p_vld = (c_win >= 0);
            if (c_win >= 0) begin
                m_last  = c_win;
                p_port  = c_win;
                p_legal = c_legal;
                p_word  = c_word;
                p_t     = c_wt;
                p_gt    = c_gt;
            end
        end
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 5))
            0:       return OFF + (32'($urandom_range(0, 2047)) << 2);
            1:       return OFF + 32'd8188;
            2:       return OFF + 32'd8192;
            3:       return OFF - 32'd4;
            4:       return $urandom;
            default: return OFF + 32'($urandom_range(0, 8191));
        endcase
    endfunction

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  wen;
        logic [31:0] add0;
        logic [31:0] add1;
        logic [1:0]  gnt;
        logic        csn;
        logic [31:0] radd;
        logic [1:0]  rv;
        logic [1:0]  err;
        logic [63:0] rd;
    } vec_t;

    localparam int NV = 10;
    vec_t vec [NV];

    initial begin
        vec[0] = '{2'b01, 2'b11, 32'h1A00_0010, 32'h0,          2'b01, 1'b0, 32'h10,
                   2'b01, 2'b00, 64'h0000_0000_DEAD_BEEF};
        vec[1] = '{2'b11, 2'b11, 32'h1A00_0000, 32'h1A00_0004,  2'b10, 1'b0, 32'h4,
                   2'b10, 2'b00, 64'hECA9_9BDE_0000_0000};
        vec[2] = '{2'b11, 2'b11, 32'h1A00_0000, 32'h1A00_0004,  2'b01, 1'b0, 32'h0,
                   2'b01, 2'b00, 64'h0000_0000_ECA8_9BDF};
        vec[3] = vec[1];
        vec[4] = vec[2];
        vec[5] = '{2'b10, 2'b01, 32'h0,          32'h1A00_0008, 2'b10, 1'b1, 32'h0,
                   2'b10, 2'b10, 64'h0};
        vec[6] = '{2'b10, 2'b11, 32'h0,          32'h1A00_2000, 2'b10, 1'b1, 32'h0,
                   2'b10, 2'b10, 64'h0};
        vec[7] = '{2'b01, 2'b11, 32'h1A00_1FFC, 32'h0,          2'b01, 1'b0, 32'h1FFC,
                   2'b01, 2'b00, 64'h0000_0000_EB57_9C20};
        vec[8] = '{2'b01, 2'b11, 32'h19FF_FFFC, 32'h0,          2'b01, 1'b1, 32'h0,
                   2'b01, 2'b01, 64'h0};
        vec[9] = '{2'b00, 2'b11, 32'h0,          32'h0,          2'b00, 1'b1, 32'h0,
                   2'b00, 2'b00, 64'h0};

        // Reset
        set_idle();
        rst_n     = 1'b0;
        rom_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n        = 1'b1;
        m_last       = NP - 1;
        p_vld        = 0;
        rom_prev_csn = 1;
        rom_prev_add = '0;

        begin_cycle();
        chk("reset_rvalid", rvalid_o, 2'b00);
        chk("reset_csn", rom_csn_o, 1'b1);
        chk("reset_rdata", rdata_o, 64'h0);
        chk("reset_taints", {rvalid_o_t0, err_o_t0, rdata_o_t0}, '0);
        end_cycle();

        // Directed vectors: request cycle, then the response in the next
        for (int i = 0; i <= NV; i++) begin
            set_idle();
            if (i < NV) begin
                req = vec[i].req;
                wen = vec[i].wen;
                add = {vec[i].add1, vec[i].add0};
            end
            begin_cycle();
            if (i < NV) begin
                chk($sformatf("vec%0d_gnt", i), gnt_o, vec[i].gnt);
                chk($sformatf("vec%0d_csn", i), rom_csn_o, vec[i].csn);
                if (!vec[i].csn) chk($sformatf("vec%0d_radd", i), rom_add_o, vec[i].radd);
            end
            if (i > 0) begin
                chk($sformatf("vec%0d_rvalid", i - 1), rvalid_o, vec[i-1].rv);
                chk($sformatf("vec%0d_err", i - 1), err_o, vec[i-1].err);
                chk($sformatf("vec%0d_rdata", i - 1), rdata_o, vec[i-1].rd);
            end
            end_cycle();
        end

        // Address taint forces a fully tainted response
        set_idle();
        req = 2'b01; add[31:0] = 32'h1A00_0010; add_t[31:0] = 32'h4;
        begin_cycle(); end_cycle();
        set_idle();
        begin_cycle();
        chk("taint_addr_rdata_t", rdata_o_t0, 64'h0000_0000_FFFF_FFFF);
        chk("taint_addr_err_t", err_o_t0, 2'b01);
        end_cycle();

        // ROM data taint passes through on a clean request
        set_idle();
        req = 2'b01; add[31:0] = 32'h1A00_0010;
        begin_cycle(); end_cycle();
        set_idle();
        rom_t = 32'h0000_00FF;
        begin_cycle();
        chk("taint_rom_rdata_t", rdata_o_t0, 64'h0000_0000_0000_00FF);
        end_cycle();

        // Tainted non-requesting contender taints every grant
        set_idle();
        req = 2'b01; add[31:0] = 32'h1A00_0020; req_t = 2'b10;
        begin_cycle();
        chk("taint_req_gnt_t", gnt_o_t0, 2'b11);
        end_cycle();
        set_idle();
        begin_cycle();
        chk("taint_req_rvalid_t", rvalid_o_t0, 2'b01);
        end_cycle();

        // Reset while a request is granted: response dropped, port 0 first after
        set_idle();
        req = 2'b01; add[31:0] = 32'h1A00_0030;
        begin_cycle(); end_cycle();
        set_idle();
        req = 2'b01; add[31:0] = 32'h1A00_0034; rst_n = 1'b0;
        begin_cycle(); end_cycle();
        set_idle();
        rst_n = 1'b1;
        begin_cycle();
        chk("rst_drop_rvalid", rvalid_o, 2'b00);
        chk("rst_drop_rdata", rdata_o, 64'h0);
        end_cycle();
        set_idle();
        req = 2'b11; add = {32'h1A00_0040, 32'h1A00_0044};
        begin_cycle();
        chk("rst_first_gnt", gnt_o, 2'b01);
        end_cycle();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            req   = 2'($urandom_range(0, 3));
            wen   = 2'b11;
            req_t = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            wen_t = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            rom_t = ($urandom_range(0, 2) == 0) ? $urandom : 32'h0;
            for (int p = 0; p < NP; p++) begin
                add[p*32 +: 32]   = pick_addr();
                wen[p]            = ($urandom_range(0, 4) != 0);
                add_t[p*32 +: 32] = ($urandom_range(0, 5) == 0) ?
                                    (32'h1 << $urandom_range(0, 31)) : 32'h0;
            end
            begin_cycle();
            end_cycle();
        end
        set_idle();
        begin_cycle();
        end_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
